// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the telemetry UART frame scheduler.
package telemetry_pkg;

  localparam int unsigned FRAME_LEN = 15;

  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } schedState_t;

  typedef struct packed {
    logic [11:0] enc1;
    logic [11:0] enc2;
    logic [7:0]  temp;
    logic [7:0]  bills;
  } frameFields_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nibbleToAscii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

endpackage

// File: rtl/frame_char_mux.sv
// Selects the ASCII character at a given position of the "EEE EEE TT BB\r\n" frame.
module frame_char_mux
  import telemetry_pkg::*;
(
  input  frameFields_t frameRegs,
  input  logic [3:0]   charIdx,
  output logic [7:0]   frameChar_c
);

  always_comb begin
    frameChar_c = 8'h00;
    case (charIdx)
      4'd0:  frameChar_c = nibbleToAscii(frameRegs.enc1[11:8]);
      4'd1:  frameChar_c = nibbleToAscii(frameRegs.enc1[7:4]);
      4'd2:  frameChar_c = nibbleToAscii(frameRegs.enc1[3:0]);
      4'd3:  frameChar_c = CHAR_SP;
      4'd4:  frameChar_c = nibbleToAscii(frameRegs.enc2[11:8]);
      4'd5:  frameChar_c = nibbleToAscii(frameRegs.enc2[7:4]);
      4'd6:  frameChar_c = nibbleToAscii(frameRegs.enc2[3:0]);
      4'd7:  frameChar_c = CHAR_SP;
      4'd8:  frameChar_c = nibbleToAscii(frameRegs.temp[7:4]);
      4'd9:  frameChar_c = nibbleToAscii(frameRegs.temp[3:0]);
      4'd10: frameChar_c = CHAR_SP;
      4'd11: frameChar_c = nibbleToAscii(frameRegs.bills[7:4]);
      4'd12: frameChar_c = nibbleToAscii(frameRegs.bills[3:0]);
      4'd13: frameChar_c = CHAR_CR;
      4'd14: frameChar_c = CHAR_LF;
      default: frameChar_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Snapshots telemetry inputs and streams one ASCII hex frame per change/keep-alive
// into async_transmitter over its start/busy handshake.
module uart_frame_scheduler
  import telemetry_pkg::*;
#(
  parameter int unsigned KEEPALIVE_TICKS = 1000,
  parameter int unsigned ACK_TIMEOUT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        force_send,
  input  logic [11:0] enc1_pos,
  input  logic [11:0] enc2_pos,
  input  logic [7:0]  temperature,
  input  logic [7:0]  bill_count,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  localparam int unsigned KaW      = (KEEPALIVE_TICKS > 1) ? $clog2(KEEPALIVE_TICKS) : 1;
  localparam int unsigned KaLimit  = (KEEPALIVE_TICKS > 0) ? KEEPALIVE_TICKS - 1 : 0;
  localparam int unsigned AckW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned AckLimit = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam int unsigned IdxW     = 4;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  schedState_t     state;
  frameFields_t    frameRegs;
  frameFields_t    shadowRegs;
  frameFields_t    liveFields;
  logic [IdxW-1:0] charIdx;
  logic [KaW-1:0]  kaCnt;
  logic [AckW-1:0] ackCnt;
  logic            pendingForce;
  logic [7:0]      frameChar;
  logic            kaExpired;
  logic            wantSend;

  assign liveFields = {enc1_pos, enc2_pos, temperature, bill_count};
  assign kaExpired  = (KEEPALIVE_TICKS != 0) && (kaCnt == KaW'(KaLimit));
  assign wantSend   = (liveFields != shadowRegs) || pendingForce || force_send || kaExpired;

  frame_char_mux uCharMux (
    .frameRegs   (frameRegs),
    .charIdx     (charIdx),
    .frameChar_c (frameChar)
  );

  // Frame sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frameRegs    <= '0;
      shadowRegs   <= '0;
      charIdx      <= '0;
      kaCnt        <= '0;
      ackCnt       <= '0;
      pendingForce <= 1'b1;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      frames_sent  <= 16'h0000;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      if (force_send) pendingForce <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            if (wantSend) begin
              state      <= SNAP;
              frame_busy <= 1'b1;
            end else if (KEEPALIVE_TICKS != 0) begin
              kaCnt <= kaCnt + KaW'(1);
            end
          end
        end

        SNAP: begin
          frameRegs <= liveFields;
          charIdx   <= '0;
          kaCnt     <= '0;
          // A force arriving during the snapshot is kept for the next tick.
          if (!force_send) pendingForce <= 1'b0;
          state <= LOAD;
        end

        LOAD: begin
          tx_data <= frameChar;
          state   <= START;
        end

        START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            ackCnt   <= '0;
            state    <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          // A transmitter that never raises busy is assumed to have taken the byte.
          if (tx_busy || (ackCnt == AckW'(AckLimit))) begin
            state <= WAIT_DONE;
          end else begin
            ackCnt <= ackCnt + AckW'(1);
          end
        end

        WAIT_DONE: begin
          if (!tx_busy) begin
            if (charIdx == LastIdx) begin
              shadowRegs  <= frameRegs;
              frames_sent <= frames_sent + 16'd1;
              frame_done  <= 1'b1;
              frame_busy  <= 1'b0;
              state       <= IDLE;
            end else begin
              charIdx <= charIdx + IdxW'(1);
              state   <= LOAD;
            end
          end
        end

        default: begin
          state      <= IDLE;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Randomized self-checking bench for uart_frame_scheduler with a behavioural
// async_transmitter model and a frame-level reference model.
module tb_uart_frame_scheduler;

  localparam int unsigned KaTicks  = 8;
  localparam int unsigned AckTo    = 4;
  localparam int          BusyHold = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        force_send = 1'b0;
  logic [11:0] enc1_pos = 12'h000;
  logic [11:0] enc2_pos = 12'h000;
  logic [7:0]  temperature = 8'h00;
  logic [7:0]  bill_count = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] frames_sent;

  always #50 clk = ~clk;

  uart_frame_scheduler #(
    .KEEPALIVE_TICKS (KaTicks),
    .ACK_TIMEOUT     (AckTo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .force_send  (force_send),
    .enc1_pos    (enc1_pos),
    .enc2_pos    (enc2_pos),
    .temperature (temperature),
    .bill_count  (bill_count),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises after a start pulse and holds for BusyHold cycles.
  bit          noBusy = 1'b0;
  int          holdLeft = 0;
  int          startCount = 0;
  int          doneCount = 0;
  logic [7:0]  gotBytes[$];

  always @(negedge clk) begin
    if (tx_start) begin
      gotBytes.push_back(tx_data);
      startCount++;
    end
    if (frame_done) doneCount++;
    if (holdLeft != 0) begin
      holdLeft--;
      if (holdLeft == 0) tx_busy = 1'b0;
    end else if (tx_start && !noBusy) begin
      tx_busy  = 1'b1;
      holdLeft = BusyHold;
    end
  end

  // Reference model state: what the scheduler should remember between ticks.
  logic [39:0] lastSent;
  bit          pendForce;
  int          kaModel;
  logic [15:0] sentModel;
  logic [7:0]  expBytes[15];

  function automatic logic [39:0] curFields();
    return {enc1_pos, enc2_pos, temperature, bill_count};
  endfunction

  function automatic void buildExpected(input logic [39:0] f);
    string hx;
    hx = "0123456789ABCDEF";
    expBytes[0]  = hx[f[39:36]];
    expBytes[1]  = hx[f[35:32]];
    expBytes[2]  = hx[f[31:28]];
    expBytes[3]  = 8'h20;
    expBytes[4]  = hx[f[27:24]];
    expBytes[5]  = hx[f[23:20]];
    expBytes[6]  = hx[f[19:16]];
    expBytes[7]  = 8'h20;
    expBytes[8]  = hx[f[15:12]];
    expBytes[9]  = hx[f[11:8]];
    expBytes[10] = 8'h20;
    expBytes[11] = hx[f[7:4]];
    expBytes[12] = hx[f[3:0]];
    expBytes[13] = 8'h0D;
    expBytes[14] = 8'h0A;
  endfunction

  function automatic void modelReset();
    lastSent  = '0;
    pendForce = 1'b1;
    kaModel   = 0;
    sentModel = 16'h0000;
  endfunction

  function automatic void modelSent(input logic [39:0] f);
    lastSent  = f;
    pendForce = 1'b0;
    kaModel   = 0;
    sentModel = sentModel + 16'd1;
  endfunction

  task automatic issueTick(input bit frc);
    @(negedge clk);
    frame_tick = 1'b1;
    force_send = frc;
    @(negedge clk);
    frame_tick = 1'b0;
    force_send = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkValue({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitBytes(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (gotBytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkValue({tag, "_bytes_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at the negedge where frame_done was first seen.
  task automatic checkFrame(input string tag, input logic [39:0] f, input int d0);
    buildExpected(f);
    checkValue({tag, "_nbytes"}, gotBytes.size(), 15);
    for (int i = 0; i < 15 && i < gotBytes.size(); i++)
      checkValue($sformatf("%s_b%0d", tag, i), gotBytes[i], expBytes[i]);
    checkValue({tag, "_count"}, frames_sent, sentModel);
    checkValue({tag, "_busy_low"}, frame_busy, 1'b0);
    @(negedge clk);
    checkValue({tag, "_done_pulse"}, doneCount - d0, 1);
    checkValue({tag, "_done_width"}, frame_done, 1'b0);
  endtask

  task automatic tickAndCheck(input bit frc, input string tag);
    logic [39:0] f;
    bit send;
    bit ok;
    int s0, d0;
    f = curFields();
    send = (f != lastSent) || pendForce || frc || (kaModel == int'(KaTicks) - 1);
    gotBytes.delete();
    s0 = startCount;
    d0 = doneCount;
    issueTick(frc);
    if (send) begin
      modelSent(f);
      waitFrameDone(tag, ok);
      if (ok) checkFrame(tag, f, d0);
    end else begin
      repeat (10) @(negedge clk);
      checkValue({tag, "_nostart"}, startCount - s0, 0);
      checkValue({tag, "_idle"}, frame_busy, 1'b0);
      if (kaModel < int'(KaTicks) - 1) kaModel++;
    end
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [39:0] f;
    bit ok;
    int s0, d0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("rst_tx_start", tx_start, 1'b0);
    checkValue("rst_tx_data", tx_data, 8'h00);
    checkValue("rst_frame_busy", frame_busy, 1'b0);
    checkValue("rst_frame_done", frame_done, 1'b0);
    checkValue("rst_frames_sent", frames_sent, 16'h0000);
    rst = 1'b0;
    modelReset();

    // First frame after reset, with tick-to-start latency
    enc1_pos = 12'h1A3; enc2_pos = 12'hFFF; temperature = 8'h19; bill_count = 8'h05;
    f = curFields();
    gotBytes.delete();
    d0 = doneCount;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checkValue("lat_snap_busy", frame_busy, 1'b1);
    checkValue("lat_c1", tx_start, 1'b0);
    @(negedge clk);
    checkValue("lat_c2", tx_start, 1'b0);
    @(negedge clk);
    checkValue("lat_c3", tx_start, 1'b0);
    @(negedge clk);
    checkValue("lat_start", tx_start, 1'b1);
    modelSent(f);
    waitFrameDone("first", ok);
    if (ok) checkFrame("first", f, d0);

    // Keep-alive: seven quiet ticks, eighth forces a frame
    for (int i = 0; i < 8; i++) tickAndCheck(1'b0, $sformatf("ka%0d", i));

    // Mid-frame input change and ignored extra tick
    f = curFields();
    gotBytes.delete();
    d0 = doneCount;
    issueTick(1'b1);
    modelSent(f);
    waitBytes("midchg", 5);
    enc1_pos = 12'h000;
    checkValue("midchg_busy", frame_busy, 1'b1);
    issueTick(1'b0);
    waitFrameDone("midchg", ok);
    if (ok) checkFrame("midchg", f, d0);
    s0 = startCount;
    repeat (40) @(negedge clk);
    checkValue("midchg_noqueue", startCount - s0, 0);
    tickAndCheck(1'b0, "changed");

    // Transmitter that never asserts busy
    noBusy = 1'b1;
    s0 = startCount;
    tickAndCheck(1'b1, "noack");
    checkValue("noack_starts", startCount - s0, 15);
    noBusy = 1'b0;

    // Reset in the middle of a frame
    enc2_pos = 12'($urandom_range(0, 4095));
    gotBytes.delete();
    issueTick(1'b0);
    waitBytes("midrst", 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkValue("midrst_tx_start", tx_start, 1'b0);
    checkValue("midrst_busy", frame_busy, 1'b0);
    checkValue("midrst_count", frames_sent, 16'h0000);
    checkValue("midrst_data", tx_data, 8'h00);
    rst = 1'b0;
    modelReset();
    tickAndCheck(1'b0, "after_rst");

    // Counter wrap, then force with unchanged inputs
    @(negedge clk);
    force dut.frames_sent = 16'hFFFE;
    @(negedge clk);
    release dut.frames_sent;
    sentModel = 16'hFFFE;
    tickAndCheck(1'b1, "wrap_a");
    tickAndCheck(1'b1, "wrap_b");
    checkValue("wrap_zero", frames_sent, 16'h0000);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: enc1_pos = 12'($urandom_range(0, 4095));
        1: enc2_pos = 12'($urandom_range(0, 4095));
        2: begin
          temperature = 8'($urandom_range(0, 255));
          bill_count  = 8'($urandom_range(0, 255));
        end
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
        pendForce = 1'b1;
      end
      tickAndCheck($urandom_range(0, 7) == 0, $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
